// File: rtl/s32_bit_adder.sv
// Registered 32-bit adder: eight 4-bit carry-lookahead blocks with the carry
// rippled between blocks, and one register stage on the result.
module s32_bit_adder #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  input  logic             carry_in,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             out_valid
);

  // Handshake: valid-only, no ready. Operands present with in_valid=1 at a
  // rising edge are always accepted; out_valid=1 marks the cycle after, when
  // sum/carry_out/overflow hold that result. With in_valid=0 the result
  // registers hold and out_valid drops.

  localparam int NBLK = WIDTH / BLOCK;

  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] prop;
  logic [WIDTH-1:0] c_bit;   // carry into each bit position
  logic [NBLK:0]    blk_c;   // carry into each lookahead block

  assign gen      = input_a & input_b;
  assign prop     = input_a ^ input_b;
  assign blk_c[0] = carry_in;

  for (genvar i = 0; i < NBLK; i++) begin : g_cla
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g    = gen[BLOCK*i +: BLOCK];
    assign p    = prop[BLOCK*i +: BLOCK];
    assign c[0] = blk_c[i];
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign c_bit[BLOCK*i +: BLOCK] = c[3:0];
    assign blk_c[i+1]              = c[4];
  end

  logic [WIDTH-1:0] sum_next;
  logic             carry_next;
  logic             ovf_next;

  assign sum_next   = prop ^ c_bit;
  assign carry_next = blk_c[NBLK];
  // Signed overflow: carry into the MSB disagrees with carry out of it.
  assign ovf_next   = c_bit[WIDTH-1] ^ blk_c[NBLK];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum       <= sum_next;
        carry_out <= carry_next;
        overflow  <= ovf_next;
      end
    end
  end

endmodule

// File: tb/tb_s32_bit_adder.sv
// Bench for s32_bit_adder: directed vector table, hold/reset sequences and
// random operands, checked through an expected-result queue.
module tb_s32_bit_adder;

  logic        clk;
  logic        rst_n;
  logic [31:0] input_a;
  logic [31:0] input_b;
  logic        carry_in;
  logic        in_valid;
  logic [31:0] sum;
  logic        carry_out;
  logic        overflow;
  logic        out_valid;

  s32_bit_adder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .input_a   (input_a),
    .input_b   (input_b),
    .carry_in  (carry_in),
    .in_valid  (in_valid),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow),
    .out_valid (out_valid)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[9];

  // expected result packed as {overflow, carry_out, sum}
  logic [33:0] exp_q[$];
  logic [33:0] last_res;
  int          n_cmp;
  int          n_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b, input logic c);
    logic [32:0] full;
    logic        ovf;
    full = {1'b0, a} + {1'b0, b} + {32'd0, c};
    ovf  = (a[31] == b[31]) && (full[31] != a[31]);
    return {ovf, full};
  endfunction

  // Called at a falling edge: drive operands, let one rising edge pass,
  // then check the registered outputs at the next falling edge.
  task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic c, input logic [33:0] expv, input string name);
    logic [33:0] e;
    in_valid = v;
    input_a  = a;
    input_b  = b;
    carry_in = c;
    if (v) exp_q.push_back(expv);
    @(posedge clk);
    @(negedge clk);
    if (v) begin
      chk({name, "_valid"}, {63'd0, out_valid}, 64'd1);
      if (exp_q.size() == 0) begin
        chk({name, "_queue"}, 64'd0, 64'd1);
      end else begin
        e = exp_q.pop_front();
        last_res = e;
        chk({name, "_result"}, {30'd0, overflow, carry_out, sum}, {30'd0, e});
      end
    end else begin
      chk({name, "_valid"}, {63'd0, out_valid}, 64'd0);
      chk({name, "_held"}, {30'd0, overflow, carry_out, sum}, {30'd0, last_res});
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    last_res = '0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    input_a  = '0;
    input_b  = '0;
    carry_in = 1'b0;

    vecs[0] = '{32'd321937,    32'd1172056,  1'b1, 32'd1493994,   1'b0, 1'b0};
    vecs[1] = '{32'd23,        32'd12,       1'b0, 32'd35,        1'b0, 1'b0};
    vecs[2] = '{32'd415362004, 32'd23907432, 1'b1, 32'd439269437, 1'b0, 1'b0};
    vecs[3] = '{32'd128,       32'd89031,    1'b0, 32'd89159,     1'b0, 1'b0};
    vecs[4] = '{32'hFFFFFFFF,  32'h0,        1'b1, 32'h0,         1'b1, 1'b0};
    vecs[5] = '{32'hAAAAAAAA,  32'h55555555, 1'b1, 32'h0,         1'b1, 1'b0};
    vecs[6] = '{32'h7FFFFFFF,  32'h1,        1'b0, 32'h80000000,  1'b0, 1'b1};
    vecs[7] = '{32'h80000000,  32'h80000000, 1'b0, 32'h0,         1'b1, 1'b1};
    vecs[8] = '{32'h0,         32'h0,        1'b0, 32'h0,         1'b0, 1'b0};

    repeat (2) @(negedge clk);
    chk("reset_outputs", {30'd0, overflow, carry_out, sum}, 64'd0);
    chk("reset_valid", {63'd0, out_valid}, 64'd0);

    // Release at a falling edge; the next rising edge is the first capture.
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cycle(1'b1, vecs[i].a, vecs[i].b, vecs[i].cin,
            {vecs[i].ovf, vecs[i].cout, vecs[i].sum}, $sformatf("vec%0d", i));
    end

    // Hold after a non-zero result.
    cycle(1'b1, 32'h7FFFFFFF, 32'h1, 1'b0, {1'b1, 1'b0, 32'h80000000}, "pre_hold");
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, $urandom, $urandom, 1'($urandom_range(1, 0)), '0, $sformatf("hold%0d", i));
    end

    // Asynchronous reset between edges with a result on the outputs.
    in_valid = 1'b1;
    input_a  = 32'd1000;
    input_b  = 32'd2000;
    carry_in = 1'b1;
    @(posedge clk);
    #2;
    chk("pre_reset_sum", {32'd0, sum}, 64'd3001);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {30'd0, overflow, carry_out, sum}, 64'd0);
    chk("async_reset_valid", {63'd0, out_valid}, 64'd0);
    // Operands presented while reset is held are discarded.
    @(negedge clk);
    input_a = 32'd5;
    input_b = 32'd6;
    @(posedge clk);
    #1;
    chk("in_reset_outputs", {29'd0, out_valid, overflow, carry_out, sum}, 64'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    last_res = '0;
    cycle(1'b0, 32'd9, 32'd9, 1'b0, '0, "post_reset_idle");
    cycle(1'b1, 32'd5, 32'd6, 1'b0, 34'd11, "post_reset_add");

    // Random back-to-back operands.
    for (int i = 0; i < 10000; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rc;
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(1, 0));
      if (i % 16 == 0) ra = {ra[31], {31{~ra[31]}}};
      cycle(1'b1, ra, rb, rc, model(ra, rb, rc), "rand");
    end

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/s32_bit_adder.md
Name: s32_bit_adder

Overview:
- Registered 32-bit binary adder with carry-in and carry-out, used as the integer add datapath element in the team's arithmetic unit.
- Datapath is structural: eight 4-bit carry-lookahead blocks, with carry rippled between blocks.
- Operands are sampled on a clock edge; the result appears one cycle later on registered outputs.

Parameters:
- WIDTH, 32, operand/result width; fixed at 32. Must be a multiple of 4 and must not be overridden.
- BLOCK, 4, lookahead block width; fixed at 4.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- input_a  input  32  operand A, unsigned
- input_b  input  32  operand B, unsigned
- carry_in  input  1  carry into bit 0
- in_valid  input  1  operands valid this cycle
- sum  output  32  registered sum bits [31:0]
- carry_out  output  1  registered carry out of bit 31
- overflow  output  1  registered two's-complement signed overflow
- out_valid  output  1  registered; high when sum, carry_out and overflow hold a fresh result

Behaviour:
- Reset: rst_n low forces sum=0, carry_out=0, overflow=0, out_valid=0 immediately, independent of clk. This also applies mid-operation; any in-flight result is discarded.
- Release: the first capture occurs on the first rising clk edge with rst_n high.
- Arithmetic: {carry_out, sum} = input_a + input_b + carry_in, computed as a 33-bit unsigned result, modulo 2^32 on sum.
- overflow = carry into bit 31 XOR carry out of bit 31, which equals (a[31]==b[31]) && (sum[31]!=a[31]).
- Combinational core: 4-bit CLA block i takes a[4i+3:4i], b[4i+3:4i] and c_i.
  - Per bit: g = a&b, p = a^b.
  - Carries: c1 = g0|p0c0, c2 = g1|p1g0|p1p0c0, up to c4. The block carry-out c4 feeds block i+1.
  - Bit sum = p ^ carry. c_0 = carry_in.
- Capture: on rising clk with in_valid=1, sum, carry_out and overflow load the new result and out_valid is set to 1.
- Hold: on rising clk with in_valid=0, sum, carry_out and overflow hold their previous values and out_valid goes to 0.
- Latency: exactly 1 cycle from the sampled edge to the output. Throughput is one add per cycle, and back-to-back valid operands are all accepted. There is no backpressure.
- Boundary cases:
  - all-ones + 0 + 1 wraps to sum=0 with carry_out=1.
  - 0 + 0 + 0 gives sum=0, carry_out=0, out_valid=1.
  - carry_in alone propagates through all 32 bits when both operands complement each other, e.g. a=0xAAAAAAAA, b=0x55555555, cin=1 gives sum=0, carry_out=1.
- No X propagation: outputs are always driven from registers.

Test Plan:
- Reset, then in_valid=1 with a=321937, b=1172056, cin=1. Next cycle: sum=1493994, carry_out=0, overflow=0, out_valid=1.
- Back-to-back operands, one per cycle:
  - a=23, b=12, cin=0 → sum=35.
  - a=415362004, b=23907432, cin=1 → sum=439269437.
  - a=128, b=89031, cin=0 → sum=89159.
  - Each result must appear exactly 1 cycle after its operands, all with carry_out=0 and out_valid=1.
- Wrap and full carry chain:
  - a=0xFFFFFFFF, b=0, cin=1 → sum=0, carry_out=1, overflow=0.
  - a=0xAAAAAAAA, b=0x55555555, cin=1 → sum=0, carry_out=1.
- Signed overflow:
  - a=0x7FFFFFFF, b=1, cin=0 → sum=0x80000000, carry_out=0, overflow=1.
  - a=0x80000000, b=0x80000000, cin=0 → sum=0, carry_out=1, overflow=1.
- Hold and reset:
  - in_valid=0 for 3 cycles → outputs keep the last result and out_valid=0.
  - Assert rst_n=0 between clock edges → all outputs go to 0 before the next edge.
- Random: 10,000 random a, b, cin with in_valid=1 → compare against the 33-bit reference sum delayed by one cycle.
